// File: rtl/ble_auth_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ble_auth_rx
//  Purpose  : UART receiver for the BLE link, plus the authorization FSM that
//             drives pwr_up from the GO/STOP command bytes and the rider
//             presence input.
//  Revision : 1.0 - initial release
// ============================================================================
module ble_auth_rx #(
    parameter int         BAUD_DIV  = 2604,
    parameter logic [7:0] GO_BYTE   = 8'h47,
    parameter logic [7:0] STOP_BYTE = 8'h53
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    localparam logic [11:0] c_baud_last = 12'(BAUD_DIV - 1);
    localparam logic [11:0] c_half_last = 12'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]  c_last_bit  = 4'd7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2}         auth_state_t;

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    rx_state_t   r_rx_state;
    logic [11:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_stop_ok;
    logic        r_stop_bad;
    auth_state_t r_auth;
    auth_state_t w_auth_next;

    // Two-flop synchronizer for the async line, plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver FSM; the stop-bit verdict is flagged at the sample edge and
    // turned into rx_data/rx_rdy/frm_err one edge later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state <= IDLE;
            r_baud_cnt <= 12'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_stop_ok  <= 1'b0;
            r_stop_bad <= 1'b0;
            rx_data    <= 8'h00;
            rx_rdy     <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            r_stop_ok  <= 1'b0;
            r_stop_bad <= 1'b0;
            rx_rdy     <= r_stop_ok;
            frm_err    <= r_stop_bad;
            if (r_stop_ok) begin
                rx_data <= r_shift;
            end
            case (r_rx_state)
                IDLE: begin
                    r_baud_cnt <= 12'd0;
                    r_bit_cnt  <= 4'd0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (r_baud_cnt == c_half_last) begin
                        r_baud_cnt <= 12'd0;
                        r_bit_cnt  <= 4'd0;
                        // Line back high at mid start bit: glitch, not a frame
                        r_rx_state <= r_rx_sync ? IDLE : DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (r_baud_cnt == c_baud_last) begin
                        r_baud_cnt <= 12'd0;
                        r_shift    <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt  <= 4'd0;
                            r_rx_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 12'd1;
                    end
                end
                STOP: begin
                    if (r_baud_cnt == c_baud_last) begin
                        r_baud_cnt <= 12'd0;
                        r_bit_cnt  <= 4'd0;
                        r_stop_ok  <= r_rx_sync;
                        r_stop_bad <= ~r_rx_sync;
                        r_rx_state <= IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 12'd1;
                    end
                end
                default: begin
                    r_rx_state <= IDLE;
                    r_baud_cnt <= 12'd0;
                    r_bit_cnt  <= 4'd0;
                end
            endcase
        end
    end

    // Authorization next-state: commands act only on rx_rdy; in PWR2 a GO
    // byte wins over the rider stepping off in the same cycle
    always_comb begin
        w_auth_next = r_auth;
        case (r_auth)
            OFF: begin
                if (rx_rdy && rx_data == GO_BYTE) begin
                    w_auth_next = PWR1;
                end
            end
            PWR1: begin
                if (rx_rdy && rx_data == STOP_BYTE) begin
                    w_auth_next = rider_off ? OFF : PWR2;
                end
            end
            PWR2: begin
                if (rx_rdy && rx_data == GO_BYTE) begin
                    w_auth_next = PWR1;
                end else if (rider_off) begin
                    w_auth_next = OFF;
                end
            end
            default: w_auth_next = OFF;
        endcase
    end

    // Auth state register; pwr_up is registered from the next state so both move together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_auth <= OFF;
            pwr_up <= 1'b0;
        end else begin
            r_auth <= w_auth_next;
            pwr_up <= (w_auth_next != OFF);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ble_auth_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ble_auth_rx
//  Purpose  : Self-checking bench for ble_auth_rx: a fast-baud instance for
//             the command table and corner cases, and a default-baud
//             instance for the full-rate byte and long false start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ble_auth_rx;

    localparam int FB = 16;
    localparam int SB = 2604;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       rider_off = 1'b0;
    logic [7:0] data_a, data_b;
    logic       rdy_a, rdy_b, frm_a, frm_b, pwr_a, pwr_b;

    int n_checks = 0;
    int n_err    = 0;

    ble_auth_rx #(.BAUD_DIV(FB)) dut_a (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .rider_off(rider_off),
        .rx_data(data_a), .rx_rdy(rdy_a), .frm_err(frm_a), .pwr_up(pwr_a)
    );

    ble_auth_rx dut_b (
        .clk(clk), .rst_n(rst_n), .RX(rx_b), .rider_off(rider_off),
        .rx_data(data_b), .rx_rdy(rdy_b), .frm_err(frm_b), .pwr_up(pwr_b)
    );

    always #5 clk = ~clk;

    // Pulse counters and pwr_up seen on the rx_rdy cycle and the cycle after
    int   a_rdy = 0, a_frm = 0, b_rdy = 0, b_frm = 0;
    logic a_cap = 1'b0, b_cap = 1'b0;
    logic a_pwr_at = 1'b0, a_pwr_after = 1'b0, b_pwr_at = 1'b0, b_pwr_after = 1'b0;

    always @(negedge clk) begin
        if (a_cap) a_pwr_after <= pwr_a;
        a_cap <= rdy_a;
        if (rdy_a) begin
            a_rdy    <= a_rdy + 1;
            a_pwr_at <= pwr_a;
        end
        if (frm_a) a_frm <= a_frm + 1;
        if (b_cap) b_pwr_after <= pwr_b;
        b_cap <= rdy_b;
        if (rdy_b) begin
            b_rdy    <= b_rdy + 1;
            b_pwr_at <= pwr_b;
        end
        if (frm_b) b_frm <= b_frm + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input bit line_b, input logic v);
        if (line_b) rx_b = v;
        else        rx_a = v;
    endtask

    // One UART frame: start, 8 data bits LSB first, stop at the given level
    task automatic send_frame(input bit line_b, input logic [7:0] d, input logic stop_hi, input int baud);
        set_rx(line_b, 1'b0);
        repeat (baud) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(line_b, d[i]);
            repeat (baud) @(negedge clk);
        end
        set_rx(line_b, stop_hi);
        repeat (baud) @(negedge clk);
        set_rx(line_b, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_hi;
        logic       rider;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_frm;
        logic       exp_pwr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int   r0, f0;
        logic prev_pwr;

        //            data   stop  rider exp_data rdy  frm  pwr
        vecs[0]  = '{8'h47, 1'b1, 1'b0, 8'h47, 1'b1, 1'b0, 1'b1}; // OFF -> PWR1
        vecs[1]  = '{8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1}; // PWR1 ignores rider_off
        vecs[2]  = '{8'h53, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0, 1'b0}; // STOP, rider off -> OFF
        vecs[3]  = '{8'h41, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0}; // OFF stays
        vecs[4]  = '{8'h53, 1'b1, 1'b0, 8'h53, 1'b1, 1'b0, 1'b0}; // STOP in OFF
        vecs[5]  = '{8'h47, 1'b0, 1'b0, 8'h53, 1'b0, 1'b1, 1'b0}; // framing error
        vecs[6]  = '{8'h47, 1'b1, 1'b0, 8'h47, 1'b1, 1'b0, 1'b1}; // OFF -> PWR1
        vecs[7]  = '{8'h53, 1'b1, 1'b0, 8'h53, 1'b1, 1'b0, 1'b1}; // PWR1 -> PWR2
        vecs[8]  = '{8'h47, 1'b1, 1'b0, 8'h47, 1'b1, 1'b0, 1'b1}; // PWR2 -> PWR1
        vecs[9]  = '{8'h53, 1'b1, 1'b0, 8'h53, 1'b1, 1'b0, 1'b1}; // PWR1 -> PWR2
        vecs[10] = '{8'h47, 1'b0, 1'b0, 8'h53, 1'b0, 1'b1, 1'b1}; // frm err in PWR2

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rx_data", {24'd0, data_a}, 32'h00);
        check("reset rx_rdy",  {31'd0, rdy_a}, 32'd0);
        check("reset frm_err", {31'd0, frm_a}, 32'd0);
        check("reset pwr_up",  {31'd0, pwr_a}, 32'd0);
        check("reset pwr_up full", {31'd0, pwr_b}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full-rate instance: 1000-cycle low glitch, then GO at the default baud
        r0 = b_rdy; f0 = b_frm;
        rx_b = 1'b0;
        repeat (1000) @(negedge clk);
        rx_b = 1'b1;
        repeat (2000) @(negedge clk);
        check("full false start rdy", b_rdy - r0, 0);
        check("full false start frm", b_frm - f0, 0);
        r0 = b_rdy; f0 = b_frm;
        send_frame(1'b1, 8'h47, 1'b1, SB);
        repeat (8) @(negedge clk);
        check("full GO rdy count", b_rdy - r0, 1);
        check("full GO frm count", b_frm - f0, 0);
        check("full GO rx_data", {24'd0, data_b}, 32'h47);
        check("full GO pwr at rdy", {31'd0, b_pwr_at}, 32'd0);
        check("full GO pwr after", {31'd0, b_pwr_after}, 32'd1);

        // Command table on the fast instance
        prev_pwr = 1'b0;
        foreach (vecs[k]) begin
            rider_off = vecs[k].rider;
            @(negedge clk);
            r0 = a_rdy; f0 = a_frm;
            send_frame(1'b0, vecs[k].data, vecs[k].stop_hi, FB);
            repeat (8) @(negedge clk);
            check($sformatf("v%0d rdy count", k), a_rdy - r0, {31'd0, vecs[k].exp_rdy});
            check($sformatf("v%0d frm count", k), a_frm - f0, {31'd0, vecs[k].exp_frm});
            check($sformatf("v%0d rx_data", k), {24'd0, data_a}, {24'd0, vecs[k].exp_data});
            check($sformatf("v%0d pwr_up", k), {31'd0, pwr_a}, {31'd0, vecs[k].exp_pwr});
            if (vecs[k].exp_rdy) begin
                check($sformatf("v%0d pwr at rdy", k), {31'd0, a_pwr_at}, {31'd0, prev_pwr});
                check($sformatf("v%0d pwr after rdy", k), {31'd0, a_pwr_after}, {31'd0, vecs[k].exp_pwr});
            end
            prev_pwr = vecs[k].exp_pwr;
        end

        // In PWR2, rider stepping off drops pwr_up one edge later
        check("pwr2 holding", {31'd0, pwr_a}, 32'd1);
        rider_off = 1'b1;
        @(posedge clk); #1;
        check("pwr2 rider off drop", {31'd0, pwr_a}, 32'd0);
        @(negedge clk);
        rider_off = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back frames with no idle gap
        r0 = a_rdy; f0 = a_frm;
        send_frame(1'b0, 8'h12, 1'b1, FB);
        send_frame(1'b0, 8'h34, 1'b1, FB);
        repeat (8) @(negedge clk);
        check("b2b rdy count", a_rdy - r0, 2);
        check("b2b frm count", a_frm - f0, 0);
        check("b2b rx_data", {24'd0, data_a}, 32'h34);

        // Short glitch shorter than half a bit
        r0 = a_rdy; f0 = a_frm;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * FB) @(negedge clk);
        check("glitch rdy", a_rdy - r0, 0);
        check("glitch frm", a_frm - f0, 0);

        // Reset in the middle of data bit 4 while authorized
        send_frame(1'b0, 8'h47, 1'b1, FB);
        repeat (8) @(negedge clk);
        check("pre-reset pwr_up", {31'd0, pwr_a}, 32'd1);
        rx_a = 1'b0;
        repeat (FB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = i[0];
            repeat (FB) @(negedge clk);
        end
        rx_a = 1'b1;
        repeat (FB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid-byte reset pwr_up", {31'd0, pwr_a}, 32'd0);
        check("mid-byte reset rx_data", {24'd0, data_a}, 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = a_rdy; f0 = a_frm;
        repeat (2 * FB) @(negedge clk);
        check("post-reset rdy", a_rdy - r0, 0);
        check("post-reset frm", a_frm - f0, 0);
        send_frame(1'b0, 8'h47, 1'b1, FB);
        repeat (8) @(negedge clk);
        check("post-reset GO rdy", a_rdy - r0, 1);
        check("post-reset GO data", {24'd0, data_a}, 32'h47);
        check("post-reset GO pwr", {31'd0, pwr_a}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ble_auth_rx.md
BLE_AUTH_RX -- requirements
Module: ble_auth_rx

Interface
REQ-001 SHALL provide parameter: BAUD_DIV, default 2604, clk cycles per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL provide parameter: GO_BYTE, default 8'h47 ('G'), authorize/power-up command.
REQ-003 SHALL provide parameter: STOP_BYTE, default 8'h53 ('S'), stop command.
REQ-004 SHALL have port: clk  input  1  system clock; the only clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port: RX  input  1  asynchronous UART serial line from the BLE module, idle high.
REQ-007 SHALL have port: rider_off  input  1  synchronous; high when load cells report no rider.
REQ-008 SHALL have port: rx_data  output  8  last correctly framed byte.
REQ-009 SHALL have port: rx_rdy  output  1  one-cycle pulse when rx_data updates.
REQ-010 SHALL have port: frm_err  output  1  one-cycle pulse on a stop-bit framing error.
REQ-011 SHALL have port: pwr_up  output  1  registered; high while the segway is authorized to balance.

Function -- receiver
REQ-012 SHALL pass RX through two flops before any use; all following references mean the synchronized RX.
REQ-013 SHALL use receiver states IDLE, START, DATA, STOP.
REQ-014 In IDLE, SHALL enter START on a synchronized falling edge of RX.
REQ-015 In START, SHALL sample RX after BAUD_DIV/2 cycles (integer divide): low -> DATA; high -> IDLE (false start, no outputs pulse).
REQ-016 In DATA, SHALL sample 8 bits, LSB first, each BAUD_DIV cycles after the previous sample, shifting them into an internal register; after bit 7 -> STOP.
REQ-017 In STOP, SHALL sample RX BAUD_DIV cycles after bit 7 and return to IDLE in the same cycle.
- Sample high: load rx_data and pulse rx_rdy on the next cycle.
- Sample low: pulse frm_err on the next cycle; rx_data unchanged; byte discarded.
REQ-018 SHALL use a 12-bit baud counter and a 4-bit bit counter, both cleared on every state entry.
REQ-019 SHALL accept a new start edge in the cycle immediately after return to IDLE (back-to-back bytes).

Function -- authorization FSM
REQ-020 SHALL use auth states OFF, PWR1 (authorized, rider expected), PWR2 (stop requested, waiting for rider to step off).
REQ-021 SHALL evaluate byte-driven transitions only in a cycle where rx_rdy=1, using rx_data.
- OFF: GO_BYTE -> PWR1; all else stays OFF.
- PWR1: STOP_BYTE with rider_off=1 -> OFF; STOP_BYTE with rider_off=0 -> PWR2; all else stays PWR1.
- PWR2: GO_BYTE -> PWR1 (priority over rider_off); otherwise rider_off=1 -> OFF (evaluated every cycle, byte or not).
REQ-022 SHALL ignore rider_off in OFF and PWR1 except as stated in REQ-021.
REQ-023 SHALL register pwr_up = (next auth state != OFF), so pwr_up changes at the same edge as the auth state.
REQ-024 Latency: pwr_up SHALL change exactly 2 clk edges after the edge that samples the stop bit (edge 1 raises rx_rdy; edge 2 updates state and pwr_up).
REQ-025 SHALL leave the auth state unchanged on a framing error or a false start.

Reset
REQ-026 While rst_n=0 at a clk edge, SHALL set: receiver IDLE; auth OFF; counters 0; rx_data=8'h00; rx_rdy=0; frm_err=0; pwr_up=0; sync flops=1.
REQ-027 Reset mid-byte SHALL discard the partial byte; a byte whose start edge falls after reset release SHALL be received normally.

Verification
REQ-028 SHALL pass: reset, send 8'h47 at BAUD_DIV=2604 -> rx_rdy pulses once with rx_data=8'h47; pwr_up=1 exactly 2 edges after the stop-bit sample.
REQ-029 SHALL pass: from PWR1 with rider_off=0, send 8'h53 -> pwr_up stays 1 (PWR2); raise rider_off=1 -> pwr_up=0 one edge later.
REQ-030 SHALL pass: from PWR1 with rider_off=1, send 8'h53 -> pwr_up=0 2 edges after the stop sample; then send 8'h41 -> rx_rdy pulses, pwr_up stays 0.
REQ-031 SHALL pass: send 8'h47 with the stop bit forced low -> frm_err pulses once, rx_rdy never pulses, pwr_up stays 0.
REQ-032 SHALL pass: drive RX low for 1000 cycles, then high -> no rx_rdy and no frm_err (false start); a following 8'h47 is received correctly.
REQ-033 SHALL pass: assert rst_n=0 at the midpoint of data bit 4 while in PWR1 -> pwr_up=0 at the next edge; a subsequent 8'h47 restores pwr_up=1.
